serial_borrow_subtractor: RTL and testbench

//  Bit-serial A - B - Bin subtractor; the subtract-direction counterpart of the ripple-carry adder.

---
 rtl/serial_borrow_subtractor_pkg.sv | 6 +
 rtl/serial_borrow_subtractor_if.sv | 14 +
 rtl/serial_borrow_subtractor_full_subtractor.sv | 11 +
 rtl/serial_borrow_subtractor.sv | 66 ++++++
 tb/tb_serial_borrow_subtractor.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/serial_borrow_subtractor_pkg.sv
// sub_pkg: shared FSM state encoding for the bit-serial subtractor.
package sub_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/serial_borrow_subtractor_if.sv
// serial_borrow_subtractor_if: start/busy/done handshake plus operands and results.
interface serial_borrow_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic [WIDTH-1:0] Borrow;
    logic             Bout;
    modport master (output start, A, B, Bin, input busy, done, Diff, Borrow, Bout);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Borrow, Bout);
endinterface

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// full_subtractor: one-bit a - b - bin stage.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor: LSB-first bit-serial A - B - Bin, one bit per clock.
module serial_borrow_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic rst_n,
    serial_borrow_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res, bv, diff_q, borrow_q;
    logic             bw, bout_q, d, bw_n, launch, last;
    assign launch = bus.start && state != ST_SHIFT;
    assign last   = state == ST_SHIFT && cnt == CW'(WIDTH - 1);
    full_subtractor u_fs (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (bw),
        .d   (d),
        .bout(bw_n)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            bw       <= 1'b0;
            res      <= '0;
            bv       <= '0;
            diff_q   <= '0;
            borrow_q <= '0;
            bout_q   <= 1'b0;
        end else if (launch) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            bw    <= bus.Bin;
        end else if (state == ST_SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            bw   <= bw_n;
            res  <= {d, res[WIDTH-1:1]};
            bv   <= {bw_n, bv[WIDTH-1:1]};
            cnt  <= last ? cnt : cnt + 1'b1;
            // Results publish only on the final bit so outputs never show partial values
            if (last) begin
                state    <= ST_DONE;
                diff_q   <= {d, res[WIDTH-1:1]};
                borrow_q <= {bw_n, bv[WIDTH-1:1]};
                bout_q   <= bw_n;
            end
        end else if (state == ST_DONE) begin
            state <= ST_IDLE;
        end
    end
    assign bus.busy   = state == ST_SHIFT;
    assign bus.done   = state == ST_DONE;
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
    assign bus.Bout   = bout_q;
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb_serial_borrow_subtractor: directed vectors, back-to-back, ignored start, reset abort, exhaustive sweep.
module tb_serial_borrow_subtractor;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic [3:0] borrow;
        logic       bout;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int lat, bcnt, held;
    vec_t tv[8];
    serial_borrow_subtractor_if #(.WIDTH(4)) bus ();
    serial_borrow_subtractor #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [3:0] bmodel(input int a, input int b, input int bin);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (a & ((1 << (i + 1)) - 1)) < ((b & ((1 << (i + 1)) - 1)) + bin);
        return r;
    endfunction
    // Launch an op and wait for done; inj >= 0 pulses a stray start (A=0,B=7) at that cycle
    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic bin, input int inj);
        logic [3:0] prev;
        int cyc;
        prev = bus.Diff;
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        bcnt = int'(bus.busy);
        held = 1;
        while (!bus.done && cyc < 12) begin
            if (cyc == inj) begin
                bus.start = 1'b1;
                bus.A = 4'd0;
                bus.B = 4'd7;
            end else bus.start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) bcnt++;
            if (!bus.done && bus.Diff !== prev) held = 0;
        end
        bus.start = 1'b0;
        lat = cyc;
    endtask
    task automatic check_op(input string tag, input logic [3:0] diff, input logic [3:0] borrow, input logic bout);
        chk({tag, " latency"}, lat, 4);
        chk({tag, " busy_cycles"}, bcnt, 4);
        chk({tag, " no_partial"}, held, 1);
        chk({tag, " diff"}, bus.Diff, diff);
        chk({tag, " borrow"}, bus.Borrow, borrow);
        chk({tag, " bout"}, bus.Bout, bout);
    endtask
    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " done_single"}, bus.done, 0);
        chk({tag, " busy_idle"}, bus.busy, 0);
    endtask
    initial begin
        tv[0] = '{4'h5, 4'h3, 1'b0, 4'h2, 4'h2, 1'b0};
        tv[1] = '{4'h2, 4'h4, 1'b1, 4'hD, 4'hD, 1'b1};
        tv[2] = '{4'hB, 4'h6, 1'b0, 4'h5, 4'h4, 1'b0};
        tv[3] = '{4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1};
        tv[4] = '{4'h9, 4'h1, 1'b0, 4'h8, 4'h0, 1'b0};
        tv[5] = '{4'hF, 4'hF, 1'b1, 4'hF, 4'hF, 1'b1};
        tv[6] = '{4'h0, 4'hF, 1'b0, 4'h1, 4'hF, 1'b1};
        tv[7] = '{4'h8, 4'h0, 1'b1, 4'h7, 4'h7, 1'b0};
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;
        #12;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset diff", bus.Diff, 0);
        chk("reset borrow", bus.Borrow, 0);
        chk("reset bout", bus.Bout, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            run(tv[i].a, tv[i].b, tv[i].bin, -1);
            check_op($sformatf("vec%0d", i), tv[i].diff, tv[i].borrow, tv[i].bout);
            idle_check($sformatf("vec%0d", i));
        end
        run(4'hB, 4'h6, 1'b0, -1);
        check_op("b2b first", 4'h5, 4'h4, 1'b0);
        run(4'h0, 4'h0, 1'b1, -1);
        check_op("b2b second", 4'hF, 4'hF, 1'b1);
        idle_check("b2b");
        run(4'h9, 4'h1, 1'b0, 1);
        check_op("ignored_start", 4'h8, 4'h0, 1'b0);
        idle_check("ignored_start");
        idle_check("ignored_start late");
        bus.A = 4'h7;
        bus.B = 4'h2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort diff", bus.Diff, 0);
        chk("abort bout", bus.Bout, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort no_done", bus.done, 0);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(4'h7, 4'h2, 1'b0, -1);
        check_op("after_reset", 4'h5, 4'h0, 1'b0);
        idle_check("after_reset");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    logic [4:0] exp;
                    exp = ({1'b0, 4'(a)} - 5'(b) - 5'(c)) & 5'h1F;
                    run(4'(a), 4'(b), 1'(c), -1);
                    check_op($sformatf("ex a=%0d b=%0d bin=%0d", a, b, c), exp[3:0], bmodel(a, b, c), exp[4]);
                    idle_check("ex");
                end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
